// File: rtl/stripe_scheduler.sv
// rtl/stripe_scheduler.sv - frames TLP/DLLP packets into the 4-lane striping byte stream
// Optional COM+SKP ordered-set insertion is enabled by defining SKP_INSERT_EN.
module stripe_scheduler #(
   parameter int SKP_INTERVAL = 1180,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tlp_req,
   input  logic [7:0] tlp_data,
   input  logic       tlp_last,
   output logic       tlp_ack,
   input  logic       dllp_req,
   input  logic [7:0] dllp_data,
   input  logic       dllp_last,
   output logic       dllp_ack,
   output logic [7:0] toStriping,
   output logic       busy
);
   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_PAD = 8'hF7;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_IDL = 8'h7C;
   localparam logic       G_TLP  = 1'b0;
   localparam logic       G_DLLP = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_DATA, S_PAD, S_END, S_SKP0, S_SKP1, S_SKP2, S_SKP3
   } state_t;

   state_t     state_q, state_d, arb_state;
   logic [1:0] pos_q, pos_d;
   logic       grant_q, grant_d, arb_grant;
   logic       rr_last_q, rr_last_d;
   logic [7:0] out_q, out_d;
   logic       busy_q, busy_d;
   logic       skp_pending, skp_clear, skp_arb;
   logic [7:0] sel_data;
   logic       sel_last;

`ifdef SKP_INSERT_EN
   logic [CNT_W-1:0] skp_cnt_q;
   logic             skp_pend_q;
   logic             skp_expire;

   assign skp_expire = (skp_cnt_q == CNT_W'(SKP_INTERVAL - 1));

   // A new expiry wins over the clear so a request is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         skp_cnt_q  <= '0;
         skp_pend_q <= 1'b0;
      end else begin
         skp_cnt_q <= skp_expire ? '0 : skp_cnt_q + CNT_W'(1);
         if (skp_expire)
            skp_pend_q <= 1'b1;
         else if (skp_clear)
            skp_pend_q <= 1'b0;
      end
   end
   assign skp_pending = skp_pend_q;
`else
   logic unused_cfg;
   assign skp_pending = 1'b0;
   assign unused_cfg  = ^{skp_clear, (SKP_INTERVAL > 0), (CNT_W > 0)};
`endif

   // The pending flag is still set during SKP3, so it must not re-trigger itself.
   assign skp_arb  = skp_pending && (state_q != S_SKP3);
   assign sel_data = (grant_q == G_DLLP) ? dllp_data : tlp_data;
   assign sel_last = (grant_q == G_DLLP) ? dllp_last : tlp_last;

   always_comb begin
      arb_state = S_IDLE;
      arb_grant = rr_last_q;
      if (skp_arb) begin
         arb_state = S_SKP0;
      end else if (tlp_req && dllp_req) begin
         arb_state = S_START;
         arb_grant = ~rr_last_q;
      end else if (tlp_req) begin
         arb_state = S_START;
         arb_grant = G_TLP;
      end else if (dllp_req) begin
         arb_state = S_START;
         arb_grant = G_DLLP;
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      grant_d   = grant_q;
      rr_last_d = rr_last_q;
      out_d     = K_IDL;
      busy_d    = 1'b0;
      tlp_ack   = 1'b0;
      dllp_ack  = 1'b0;
      skp_clear = 1'b0;
      case (state_q)
         S_IDLE: begin
            pos_d   = 2'd0;
            state_d = arb_state;
            grant_d = arb_grant;
         end
         S_START: begin
            out_d     = (grant_q == G_DLLP) ? K_SDP : K_STP;
            busy_d    = 1'b1;
            rr_last_d = grant_q;
            pos_d     = 2'd1;
            state_d   = S_DATA;
         end
         S_DATA: begin
            out_d    = sel_data;
            busy_d   = 1'b1;
            tlp_ack  = (grant_q == G_TLP);
            dllp_ack = (grant_q == G_DLLP);
            pos_d    = pos_q + 2'd1;
            if (sel_last)
               state_d = (pos_q == 2'd2) ? S_END : S_PAD;
         end
         S_PAD: begin
            out_d  = K_PAD;
            busy_d = 1'b1;
            pos_d  = pos_q + 2'd1;
            if (pos_q == 2'd2)
               state_d = S_END;
         end
         S_END: begin
            out_d   = K_END;
            busy_d  = 1'b1;
            pos_d   = 2'd0;
            state_d = arb_state;
            grant_d = arb_grant;
         end
         S_SKP0: begin
            out_d   = K_COM;
            state_d = S_SKP1;
         end
         S_SKP1: begin
            out_d   = K_SKP;
            state_d = S_SKP2;
         end
         S_SKP2: begin
            out_d   = K_SKP;
            state_d = S_SKP3;
         end
         S_SKP3: begin
            out_d     = K_SKP;
            skp_clear = 1'b1;
            state_d   = arb_state;
            grant_d   = arb_grant;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pos_q     <= 2'd0;
         grant_q   <= G_TLP;
         rr_last_q <= G_TLP;
         out_q     <= K_IDL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         grant_q   <= grant_d;
         rr_last_q <= rr_last_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
      end
   end

   assign toStriping = out_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_stripe_scheduler.sv
// tb/tb_stripe_scheduler.sv - randomized and directed bench for stripe_scheduler
module tb_stripe_scheduler;
   localparam logic [7:0] COM  = 8'hBC;
   localparam logic [7:0] PADC = 8'hF7;
   localparam logic [7:0] SKP  = 8'h1C;
   localparam logic [7:0] STP  = 8'hFB;
   localparam logic [7:0] SDP  = 8'h5C;
   localparam logic [7:0] ENDC = 8'hFD;
   localparam logic [7:0] IDL  = 8'h7C;
   localparam int         SKP_IV = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tlp_req = 1'b0, tlp_last = 1'b0, dllp_req = 1'b0, dllp_last = 1'b0;
   logic [7:0] tlp_data = 8'h00, dllp_data = 8'h00;
   logic       tlp_ack, dllp_ack, busy;
   logic [7:0] toStriping;

   stripe_scheduler #(.SKP_INTERVAL(SKP_IV), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .tlp_req(tlp_req), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ack(tlp_ack),
      .dllp_req(dllp_req), .dllp_data(dllp_data), .dllp_last(dllp_last), .dllp_ack(dllp_ack),
      .toStriping(toStriping), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // requester sources and the reference model's copy of every packet
   logic [7:0] t_bytes[$], d_bytes[$], mt_bytes[$], md_bytes[$];
   bit         t_lastq[$], d_lastq[$], mt_last[$], md_last[$];
   logic [7:0] exp_q[$], obs[$], filt[$];
   bit         obs_busy[$];
   int         skp_pos[$];
   int         t_ack_cnt, d_ack_cnt, both_ack, t_pushed, d_pushed, bad_skp;

   function automatic logic [7:0] rand_byte();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255));
      while (b == ENDC || b == IDL || b == COM || b == SKP);
      return b;
   endfunction

   function automatic void push_byte(input bit is_dllp, input logic [7:0] b, input bit last);
      if (is_dllp) begin
         d_bytes.push_back(b); d_lastq.push_back(last);
         md_bytes.push_back(b); md_last.push_back(last); d_pushed++;
      end else begin
         t_bytes.push_back(b); t_lastq.push_back(last);
         mt_bytes.push_back(b); mt_last.push_back(last); t_pushed++;
      end
   endfunction

   function automatic void push_rand_pkt(input bit is_dllp, input int n);
      for (int i = 0; i < n; i++) push_byte(is_dllp, rand_byte(), i == n - 1);
   endfunction

   // Frame = header + data + PAD up to a 4-byte multiple + END.
   function automatic void emit_frame(input bit is_dllp);
      int n = 0;
      bit done = 0;
      exp_q.push_back(is_dllp ? SDP : STP);
      while (!done && (is_dllp ? md_bytes.size() : mt_bytes.size()) > 0) begin
         if (is_dllp) begin
            exp_q.push_back(md_bytes.pop_front()); done = md_last.pop_front();
         end else begin
            exp_q.push_back(mt_bytes.pop_front()); done = mt_last.pop_front();
         end
         n++;
      end
      while ((n + 2) % 4 != 0) begin
         exp_q.push_back(PADC); n++;
      end
      exp_q.push_back(ENDC);
   endfunction

   function automatic void strip_skp();
      filt.delete(); skp_pos.delete(); bad_skp = 0;
      for (int i = 0; i < obs.size(); i++) begin
         if (obs[i] == COM) begin
            skp_pos.push_back(i);
            if (i == 0 || i + 3 >= obs.size()) bad_skp++;
            else begin
               if (obs[i+1] != SKP || obs[i+2] != SKP || obs[i+3] != SKP) bad_skp++;
               if (obs[i-1] != ENDC && obs[i-1] != IDL) bad_skp++;
            end
            i += 3;
         end else if (!(filt.size() == 0 && obs[i] == IDL)) begin
            filt.push_back(obs[i]);
         end
      end
   endfunction

   function automatic int first_frame_idx();
      for (int i = 0; i < obs.size(); i++) if (obs[i] != IDL) return i;
      return -1;
   endfunction

   task automatic drive();
      tlp_req = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0;
      dllp_req = 1'b0; dllp_data = 8'h00; dllp_last = 1'b0;
      if (t_bytes.size() > 0) begin
         tlp_req = 1'b1; tlp_data = t_bytes[0]; tlp_last = t_lastq[0];
      end
      if (d_bytes.size() > 0) begin
         dllp_req = 1'b1; dllp_data = d_bytes[0]; dllp_last = d_lastq[0];
      end
   endtask

   task automatic step();
      bit ta, da;
      @(negedge clk);
      ta = tlp_ack; da = dllp_ack;
      if (ta && da) both_ack++;
      @(posedge clk);
      #1;
      if (ta) begin
         t_ack_cnt++;
         if (t_bytes.size() > 0) begin void'(t_bytes.pop_front()); void'(t_lastq.pop_front()); end
      end
      if (da) begin
         d_ack_cnt++;
         if (d_bytes.size() > 0) begin void'(d_bytes.pop_front()); void'(d_lastq.pop_front()); end
      end
      drive();
      obs.push_back(toStriping);
      obs_busy.push_back(busy);
   endtask

   task automatic clear_all();
      t_bytes.delete(); d_bytes.delete(); t_lastq.delete(); d_lastq.delete();
      mt_bytes.delete(); md_bytes.delete(); mt_last.delete(); md_last.delete();
      exp_q.delete(); obs.delete(); obs_busy.delete();
      t_ack_cnt = 0; d_ack_cnt = 0; both_ack = 0; t_pushed = 0; d_pushed = 0;
   endtask

   task automatic do_reset();
      clear_all();
      drive();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      obs.delete(); obs_busy.delete();
      t_ack_cnt = 0; d_ack_cnt = 0; both_ack = 0;
   endtask

   task automatic drain(input string tag);
      int budget = 3000;
      while ((t_bytes.size() > 0 || d_bytes.size() > 0) && budget > 0) begin
         step(); budget--;
      end
      vectors++;
      if (budget == 0) begin
         miscompares++;
         $display("FAIL %s_timeout: bytes left %0d required 0", tag, t_bytes.size() + d_bytes.size());
      end
      repeat (10) step();
   endtask

   task automatic test_reset();
      clear_all();
      drive();
      reset = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs[i] !== IDL) begin
            miscompares++; $display("FAIL reset_hold[%0d]: got %h required %h", i, obs[i], IDL);
         end
      end
      reset = 1'b0;
      obs.delete(); obs_busy.delete();
      repeat (8) step();
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (obs[i] !== IDL || obs_busy[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle[%0d]: got %h/busy %0b required %h/busy 0", i, obs[i], obs_busy[i], IDL);
         end
      end
      vectors++;
      if (t_ack_cnt + d_ack_cnt !== 0) begin
         miscompares++; $display("FAIL reset_acks: got %0d required 0", t_ack_cnt + d_ack_cnt);
      end
   endtask

   task automatic check_literal(input string tag, input logic [7:0] want[$]);
      int f = first_frame_idx();
      vectors++;
      if (f < 0 || f + want.size() > obs.size()) begin
         miscompares++; $display("FAIL %s_start: frame index %0d not found", tag, f);
         return;
      end
      for (int i = 0; i < want.size(); i++) begin
         vectors++;
         if (obs[f+i] !== want[i]) begin
            miscompares++; $display("FAIL %s[%0d]: got %h required %h", tag, i, obs[f+i], want[i]);
         end
      end
   endtask

   task automatic test_tlp_two();
      logic [7:0] want[$];
      int f;
      do_reset();
      push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 1);
      drive();
      drain("tlp_two");
      want = '{STP, 8'hA1, 8'hA2, ENDC};
      check_literal("tlp_two", want);
      f = first_frame_idx();
      vectors++;
      if (f >= 0 && obs[f+4] !== IDL) begin
         miscompares++; $display("FAIL tlp_two_after: got %h required %h", obs[f+4], IDL);
      end
      vectors++;
      if (t_ack_cnt !== 2 || d_ack_cnt !== 0) begin
         miscompares++; $display("FAIL tlp_two_acks: got tlp %0d dllp %0d required 2 0", t_ack_cnt, d_ack_cnt);
      end
   endtask

   task automatic test_dllp_pad();
      logic [7:0] want[$];
      do_reset();
      push_byte(1, 8'hB1, 0); push_byte(1, 8'hB2, 0); push_byte(1, 8'hB3, 1);
      drive();
      drain("dllp_pad");
      want = '{SDP, 8'hB1, 8'hB2, 8'hB3, PADC, PADC, PADC, ENDC};
      check_literal("dllp_pad", want);
      vectors++;
      if (d_ack_cnt !== 3 || t_ack_cnt !== 0) begin
         miscompares++; $display("FAIL dllp_pad_acks: got dllp %0d tlp %0d required 3 0", d_ack_cnt, t_ack_cnt);
      end
   endtask

   task automatic test_tie();
      logic [7:0] want[$];
      do_reset();
      push_byte(0, 8'hE1, 0); push_byte(0, 8'hE2, 1);
      push_byte(1, 8'hD1, 0); push_byte(1, 8'hD2, 1);
      drive();
      drain("tie");
      want = '{SDP, 8'hD1, 8'hD2, ENDC, STP, 8'hE1, 8'hE2, ENDC};
      check_literal("tie", want);
      vectors++;
      if (both_ack !== 0) begin
         miscompares++; $display("FAIL tie_dual_ack: got %0d cycles required 0", both_ack);
      end
   endtask

   task automatic test_back_to_back();
      int nt = 0, nd = 0, busy_cnt = 0, tail_bad = 0;
      bit last_dllp = 0;
      logic [7:0] got;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         push_rand_pkt(0, $urandom_range(1, 9)); nt++;
         push_rand_pkt(1, $urandom_range(1, 9)); nd++;
      end
      for (int i = 0; i < 1 + $urandom_range(0, 3); i++) begin
         push_rand_pkt(0, $urandom_range(1, 12)); nt++;
      end
      drive();
      drain("b2b");
      // both requesters stay asserted, so grants alternate starting with DLLP
      while (nt > 0 && nd > 0) begin
         emit_frame(!last_dllp);
         if (!last_dllp) nd--; else nt--;
         last_dllp = !last_dllp;
      end
      while (nt > 0) begin emit_frame(0); nt--; end
      while (nd > 0) begin emit_frame(1); nd--; end
      strip_skp();
      vectors++;
      if (bad_skp !== 0) begin
         miscompares++; $display("FAIL b2b_skp_frame: got %0d bad sets required 0", bad_skp);
      end
`ifndef SKP_INSERT_EN
      vectors++;
      if (skp_pos.size() !== 0) begin
         miscompares++; $display("FAIL b2b_no_skp: got %0d sets required 0", skp_pos.size());
      end
`endif
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < filt.size()) ? filt[i] : 8'hxx;
         vectors++;
         if (got !== exp_q[i]) begin
            miscompares++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, got, exp_q[i]);
         end
      end
      for (int i = exp_q.size(); i < filt.size(); i++) if (filt[i] !== IDL) tail_bad++;
      vectors++;
      if (tail_bad !== 0) begin
         miscompares++; $display("FAIL b2b_tail: got %0d non-idle bytes required 0", tail_bad);
      end
      foreach (obs_busy[i]) busy_cnt += obs_busy[i];
      vectors++;
      if (busy_cnt !== exp_q.size()) begin
         miscompares++; $display("FAIL b2b_busy: got %0d cycles required %0d", busy_cnt, exp_q.size());
      end
      vectors++;
      if (t_ack_cnt !== t_pushed || d_ack_cnt !== d_pushed || both_ack !== 0) begin
         miscompares++;
         $display("FAIL b2b_acks: got tlp %0d dllp %0d dual %0d required %0d %0d 0",
                  t_ack_cnt, d_ack_cnt, both_ack, t_pushed, d_pushed);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pkt[$];
      logic [7:0] got;
      int f;
      do_reset();
      for (int i = 0; i < 10; i++) pkt.push_back(rand_byte());
      for (int i = 0; i < 10; i++) push_byte(0, pkt[i], i == 9);
      drive();
      repeat (4) step();
      vectors++;
      if (obs[1] !== STP || obs[2] !== pkt[0]) begin
         miscompares++; $display("FAIL mid_pre: got %h %h required %h %h", obs[1], obs[2], STP, pkt[0]);
      end
      reset = 1'b1;
      step();
      vectors++;
      if (obs[4] !== IDL || tlp_ack !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got %h ack %0b busy %0b required %h 0 0", obs[4], tlp_ack, busy, IDL);
      end
      reset = 1'b0;
      clear_all();
      for (int i = 0; i < 10; i++) push_byte(0, pkt[i], i == 9);
      drive();
      drain("mid_reissue");
      emit_frame(0);
      f = first_frame_idx();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (f >= 0 && f + i < obs.size()) ? obs[f+i] : 8'hxx;
         vectors++;
         if (got !== exp_q[i]) begin
            miscompares++; $display("FAIL mid_reissue[%0d]: got %h required %h", i, got, exp_q[i]);
         end
      end
   endtask

`ifdef SKP_INSERT_EN
   task automatic test_skp();
      int lo, hi;
      logic [7:0] got;
      do_reset();
      for (int i = 0; i < 15; i++) push_rand_pkt(0, 6);
      drive();
      drain("skp");
      for (int i = 0; i < 15; i++) emit_frame(0);
      strip_skp();
      vectors++;
      if (bad_skp !== 0) begin
         miscompares++; $display("FAIL skp_placement: got %0d bad sets required 0", bad_skp);
      end
      vectors++;
      if (skp_pos.size() < 4) begin
         miscompares++; $display("FAIL skp_count: got %0d required at least 4", skp_pos.size());
      end
      // the k-th expiry ends cycle k*SKP_IV-1; COM may wait at most one 8-byte frame
      for (int k = 0; k < skp_pos.size(); k++) begin
         lo = SKP_IV * (k + 1) + 1;
         hi = lo + 8;
         vectors++;
         if (skp_pos[k] < lo || skp_pos[k] > hi) begin
            miscompares++; $display("FAIL skp_window[%0d]: got cycle %0d required %0d..%0d", k, skp_pos[k], lo, hi);
         end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < filt.size()) ? filt[i] : 8'hxx;
         vectors++;
         if (got !== exp_q[i]) begin
            miscompares++; $display("FAIL skp_stream[%0d]: got %h required %h", i, got, exp_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tlp_two();
      test_dllp_pad();
      test_tie();
      test_back_to_back();
      test_reset_mid();
`ifdef SKP_INSERT_EN
      test_skp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/stripe_scheduler.md
Name: stripe_scheduler

Overview:
- Sequences the byte stream that feeds the 4-lane byte-striping block (input `fromMux`), one byte per clk.
- Arbitrates between a TLP requester and a DLLP requester and frames each packet as STP/SDP + data + PAD + END, so END always lands on lane 3.
- Emits IDL when there is no traffic.
- Optionally inserts periodic COM+SKP ordered sets.

Parameters:
- SKP_INTERVAL, 1180, clk cycles between SKP ordered-set requests (used only with SKP_INSERT_EN).
- CNT_W, 16, width of the SKP interval counter; SKP_INTERVAL must be < 2^CNT_W.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- tlp_req  in  1  TLP requester has a packet; held high until its last byte is acked.
- tlp_data  in  8  current TLP data byte.
- tlp_last  in  1  tlp_data is the final byte.
- tlp_ack  out  1  tlp_data consumed this cycle.
- dllp_req  in  1  DLLP requester has a packet.
- dllp_data  in  8  current DLLP data byte.
- dllp_last  in  1  dllp_data is the final byte.
- dllp_ack  out  1  dllp_data consumed this cycle.
- toStriping  out  8  registered byte to the striping block.
- busy  out  1  high from START through END inclusive.

Behaviour:
- Symbols: COM=BC, PAD=F7, SKP=1C, STP=FB, SDP=5C, END=FD, IDL=7C.
- Reset (sampled high at posedge):
  - state=IDLE, toStriping=IDL, acks=0, busy=0.
  - pos=0, rr_last=TLP (so DLLP wins the first tie).
  - SKP counter=0, skp_pending=0.
  - Reset mid-packet abandons the frame; IDL is output from the next cycle. Requesters must restart their packets.
- toStriping is registered: the decision made in cycle N appears at the posedge ending N. An acked byte is visible on toStriping one cycle after ack.
- pos is a 2-bit lane position. STP/SDP is pos 0; pos increments on every framed byte.
- States:
  - IDLE: output IDL, pos=0. Arbitrate in this order:
    - skp_pending → SKP0.
    - Else one request → START for that requester.
    - Else both requests → the requester != rr_last.
    - Else stay in IDLE.
  - START: output STP (TLP) or SDP (DLLP); latch the grant into rr_last; pos=1 → DATA.
  - DATA: ack the granted requester (Moore; ack=1 for the whole state); output its data byte; pos++.
    - If last and the new pos==3 → END.
    - If last and the new pos!=3 → PAD.
    - Otherwise stay in DATA.
  - PAD: output PAD, pos++; when the new pos==3 → END.
  - END: output END, pos=0. Re-arbitrate as in IDLE; back-to-back packets go directly to START with no IDL gap.
  - SKP0..SKP3: output COM, SKP, SKP, SKP; clear skp_pending on SKP3; then re-arbitrate.
- Total frame length (START..END) is always a multiple of 4 bytes.
- Minimum frame: 1 data byte gives STP, D, PAD, END.
- A request arriving during DATA/PAD/END of another packet waits. The ack of the non-granted requester is always 0.
- A req deasserted before last is a protocol violation. The controller keeps acking and sending the held data byte until last is seen.
- Data bytes equal to K-code values are not escaped; the source must not send END (FD) as data.

Optional Feature:
- Macro SKP_INSERT_EN.
- Defined:
  - Counter increments every cycle and wraps to 0 on reaching SKP_INTERVAL-1, setting skp_pending.
  - skp_pending is serviced only at IDLE or after END, never mid-frame.
  - If pending is set again while already set, it stays 1; no queueing of multiple requests.
  - SKP beats any packet request at arbitration.
- Undefined: the counter, skp_pending and SKP states are absent; only IDL and packets are emitted.

Test Plan:
- Reset held 3 cycles then released with no requests → toStriping=7C every cycle, acks 0, busy 0.
- TLP 2 bytes A1,A2 (last on A2) → FB,A1,A2,FD; tlp_ack high exactly 2 cycles; then 7C.
- DLLP 3 bytes B1,B2,B3 → 5C,B1,B2,B3,F7,F7,F7,FD (8 bytes, END at pos 3).
- tlp_req and dllp_req raised in the same cycle, each 2 bytes → DLLP frame first (5C..FD), immediately followed by TLP frame (FB..FD), no 7C between.
- SKP_INSERT_EN with SKP_INTERVAL=20, continuous 6-byte TLPs → BC,1C,1C,1C appears only directly after an FD, within one frame time of each interval expiry.
- Reset asserted while in DATA of a 10-byte TLP → next toStriping=7C, tlp_ack=0, pos=0; the packet re-issued afterwards is framed from FB.
